// File: rtl/tdm_demux.sv
// tdm_demux: receive side of the TDM link; locks to frame sync and splits the serial stream into CH_NUM slot words.
// Optional trailing even-parity bit per slot (adds par_err): define TDM_DEMUX_PARITY_EN.
module tdm_demux #(
   parameter int CH_NUM = 4,
   parameter int SLOT_W = 8
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst_n,
   input  logic                     din,
   input  logic                     din_en,
   input  logic                     frm_sync,
   output logic [CH_NUM*SLOT_W-1:0] ch_data,
   output logic [CH_NUM-1:0]        ch_valid,
   output logic                     frm_done,
   output logic                     locked,
   output logic                     sync_err
`ifdef TDM_DEMUX_PARITY_EN
   ,
   output logic [CH_NUM-1:0]        par_err
`endif
);

`ifdef TDM_DEMUX_PARITY_EN
   localparam int SLOT_LEN = SLOT_W + 1;
`else
   localparam int SLOT_LEN = SLOT_W;
`endif
   // The final data bit is taken straight from din, so without parity the shifter needs one bit less.
   localparam int SHW = SLOT_LEN - 1;
   localparam int BW  = $clog2(SLOT_LEN);
   localparam int CHW = $clog2(CH_NUM);

   typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_t;

   state_t                        state, state_nxt;
   logic [BW-1:0]                 bit_cnt, bit_cnt_nxt;
   logic [CHW-1:0]                ch_cnt, ch_cnt_nxt;
   logic [SHW-1:0]                sh, sh_nxt, sh_in;
   logic [SLOT_W-1:0]             word_nxt;
   logic [CH_NUM-1:0][SLOT_W-1:0] words;
   logic                          load;
   logic [CH_NUM-1:0]             valid_nxt;
   logic                          done_nxt, serr_nxt;
   logic                          frame_start, last_bit;
`ifdef TDM_DEMUX_PARITY_EN
   logic [CH_NUM-1:0]             perr_nxt;

   function automatic logic slot_parity(input logic [SLOT_W-1:0] d, input logic p);
      return (^d) ^ p;
   endfunction
`endif

   assign sh_in       = SHW'({sh, din});
   assign frame_start = (bit_cnt == '0) && (ch_cnt == '0);
   assign last_bit    = (bit_cnt == BW'(SLOT_LEN - 1));
   assign ch_data     = words;
   assign locked      = (state == RECV);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= HUNT;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (din_en) begin
         case (state)
            HUNT:    if (frm_sync) state_nxt = RECV;
            RECV:    if (frame_start && !frm_sync) state_nxt = HUNT;
            default: state_nxt = HUNT;
         endcase
      end
   end

   always_comb begin
      bit_cnt_nxt = bit_cnt;
      ch_cnt_nxt  = ch_cnt;
      sh_nxt      = sh;
      load        = 1'b0;
      valid_nxt   = '0;
      done_nxt    = 1'b0;
      serr_nxt    = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      word_nxt    = sh;
      perr_nxt    = '0;
`else
      word_nxt    = {sh, din};
`endif
      if (din_en) begin
         if (state == HUNT) begin
            if (frm_sync) begin
               sh_nxt      = sh_in;
               bit_cnt_nxt = BW'(1);
               ch_cnt_nxt  = '0;
            end
         end else if (frame_start && !frm_sync) begin
            serr_nxt    = 1'b1;
            sh_nxt      = '0;
            bit_cnt_nxt = '0;
            ch_cnt_nxt  = '0;
         end else if (frm_sync && !frame_start) begin
            // Early sync: drop the partial slot and restart the frame on this bit.
            serr_nxt    = 1'b1;
            sh_nxt      = sh_in;
            bit_cnt_nxt = BW'(1);
            ch_cnt_nxt  = '0;
         end else if (last_bit) begin
            load              = 1'b1;
            valid_nxt[ch_cnt] = 1'b1;
            bit_cnt_nxt       = '0;
`ifdef TDM_DEMUX_PARITY_EN
            perr_nxt[ch_cnt]  = slot_parity(sh, din);
`else
            sh_nxt            = sh_in;
`endif
            if (ch_cnt == CHW'(CH_NUM - 1)) begin
               ch_cnt_nxt = '0;
               done_nxt   = 1'b1;
            end else begin
               ch_cnt_nxt = ch_cnt + CHW'(1);
            end
         end else begin
            sh_nxt      = sh_in;
            bit_cnt_nxt = bit_cnt + BW'(1);
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         bit_cnt  <= '0;
         ch_cnt   <= '0;
         sh       <= '0;
         words    <= '0;
         ch_valid <= '0;
         frm_done <= 1'b0;
         sync_err <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
         par_err  <= '0;
`endif
      end else begin
         bit_cnt  <= bit_cnt_nxt;
         ch_cnt   <= ch_cnt_nxt;
         sh       <= sh_nxt;
         ch_valid <= valid_nxt;
         frm_done <= done_nxt;
         sync_err <= serr_nxt;
`ifdef TDM_DEMUX_PARITY_EN
         par_err  <= perr_nxt;
`endif
         if (load) words[ch_cnt] <= word_nxt;
      end
   end

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: randomized scenarios for tdm_demux checked cycle by cycle against a frame-position reference model.
// Parity scenario is built only when TDM_DEMUX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_tdm_demux;
   localparam int CH_NUM = 4;
   localparam int SLOT_W = 8;
`ifdef TDM_DEMUX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int SL    = SLOT_W + (PAR ? 1 : 0);
   localparam int FRAME = CH_NUM * SL;
   localparam int VW    = CH_NUM * SLOT_W + 2 * CH_NUM + 3;
   localparam logic [CH_NUM*SLOT_W-1:0] CLEAN = 32'h01FF3CA5;

   logic                     sys_clk = 1'b0;
   logic                     sys_rst_n = 1'b0;
   logic                     din = 1'b0;
   logic                     din_en = 1'b0;
   logic                     frm_sync = 1'b0;
   logic [CH_NUM*SLOT_W-1:0] ch_data;
   logic [CH_NUM-1:0]        ch_valid;
   logic                     frm_done, locked, sync_err;
`ifdef TDM_DEMUX_PARITY_EN
   logic [CH_NUM-1:0]        par_err;
`endif

   tdm_demux #(.CH_NUM(CH_NUM), .SLOT_W(SLOT_W)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .din(din), .din_en(din_en), .frm_sync(frm_sync),
      .ch_data(ch_data), .ch_valid(ch_valid), .frm_done(frm_done), .locked(locked), .sync_err(sync_err)
`ifdef TDM_DEMUX_PARITY_EN
      , .par_err(par_err)
`endif
   );

   always #5 sys_clk = ~sys_clk;

   int checks = 0;
   int errors = 0;

   // Reference model: one position index into the frame instead of separate bit/channel counters.
   bit                       m_locked;
   int                       m_pos;
   logic [31:0]              m_acc;
   logic [CH_NUM*SLOT_W-1:0] m_data;
   logic [CH_NUM-1:0]        m_valid, m_par;
   logic                     m_done, m_err;
   logic [1:0]               q[$];

   task automatic model_reset();
      m_locked = 1'b0; m_pos = 0; m_acc = '0; m_data = '0;
      m_valid = '0; m_par = '0; m_done = 1'b0; m_err = 1'b0;
   endtask

   task automatic model_step(input logic b, input logic en, input logic s);
      int idx, slot;
      m_valid = '0; m_par = '0; m_done = 1'b0; m_err = 1'b0;
      if (!en) return;
      if (!m_locked) begin
         if (s) begin m_locked = 1'b1; m_pos = 1; m_acc = {31'b0, b}; end
      end else if (m_pos == 0 && !s) begin
         m_err = 1'b1; m_locked = 1'b0;
      end else if (s && m_pos != 0) begin
         m_err = 1'b1; m_pos = 1; m_acc = {31'b0, b};
      end else begin
         idx  = m_pos % SL;
         slot = m_pos / SL;
         if (PAR && idx == SL - 1) m_par[slot] = (^m_acc[SLOT_W-1:0]) ^ b;
         else                      m_acc = {m_acc[30:0], b};
         m_pos++;
         if (idx == SL - 1) begin
            m_data[slot*SLOT_W +: SLOT_W] = m_acc[SLOT_W-1:0];
            m_valid[slot] = 1'b1;
            if (m_pos == FRAME) begin m_done = 1'b1; m_pos = 0; end
         end
      end
   endtask

   function automatic logic [VW-1:0] obs();
      logic [CH_NUM-1:0] p = '0;
`ifdef TDM_DEMUX_PARITY_EN
      p = par_err;
`endif
      return {ch_data, ch_valid, p, frm_done, locked, sync_err};
   endfunction

   function automatic logic [VW-1:0] expv();
      return {m_data, m_valid, m_par, m_done, m_locked, m_err};
   endfunction

   function automatic logic [CH_NUM*SLOT_W-1:0] rand_frame();
      logic [CH_NUM*SLOT_W-1:0] f;
      for (int c = 0; c < CH_NUM; c++) f[c*SLOT_W +: SLOT_W] = SLOT_W'($urandom);
      return f;
   endfunction

   task automatic push_frame(input logic [CH_NUM*SLOT_W-1:0] f, input logic sync0, input logic [CH_NUM-1:0] bad_par);
      for (int c = 0; c < CH_NUM; c++) begin
         for (int i = SLOT_W - 1; i >= 0; i--)
            q.push_back({f[c*SLOT_W + i], (c == 0 && i == SLOT_W - 1) ? sync0 : 1'b0});
         if (PAR) q.push_back({(^f[c*SLOT_W +: SLOT_W]) ^ bad_par[c], 1'b0});
      end
   endtask

   task automatic drive(input logic b, input logic en, input logic s);
      din = b; din_en = en; frm_sync = s;
      @(posedge sys_clk);
      model_step(b, en, s);
      #1;
   endtask

   task automatic do_reset();
      @(negedge sys_clk);
      sys_rst_n = 1'b0; din = 1'b0; din_en = 1'b0; frm_sync = 1'b0;
      model_reset();
      q.delete();
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0; din = 1'b1; din_en = 1'b1; frm_sync = 1'b1;
      model_reset();
      repeat (3) @(posedge sys_clk);
      #1;
      if (obs() !== '0) begin errors++; $display("FAIL reset_state got %h want 0", obs()); end
      checks++;
      @(negedge sys_clk);
      sys_rst_n = 1'b1; din_en = 1'b0; frm_sync = 1'b0;
   endtask

   task automatic test_clean_frame();
      int ev_idx[$];
      logic [CH_NUM-1:0] ev_val[$];
      int nerr = 0;
      do_reset();
      push_frame(CLEAN, 1'b1, '0);
      for (int i = 0; i < q.size(); i++) begin
         drive(q[i][1], 1'b1, q[i][0]);
         if (obs() !== expv()) begin errors++; $display("FAIL clean[%0d] got %h want %h", i, obs(), expv()); end
         checks++;
         if (frm_done !== ch_valid[CH_NUM-1]) begin errors++; $display("FAIL clean_done_align[%0d] got %b want %b", i, frm_done, ch_valid[CH_NUM-1]); end
         checks++;
         if (ch_valid != '0) begin ev_idx.push_back(i); ev_val.push_back(ch_valid); end
         if (sync_err) nerr++;
      end
      if (ev_idx.size() !== CH_NUM) begin errors++; $display("FAIL clean_pulse_count got %0d want %0d", ev_idx.size(), CH_NUM); end
      checks++;
      for (int k = 0; k < ev_idx.size() && k < CH_NUM; k++) begin
         if (ev_val[k] !== CH_NUM'(1 << k) || ev_idx[k] !== SL - 1 + k * SL) begin
            errors++; $display("FAIL clean_pulse%0d got %b@%0d want %b@%0d", k, ev_val[k], ev_idx[k], CH_NUM'(1 << k), SL - 1 + k * SL);
         end
         checks++;
      end
      if (ch_data !== CLEAN) begin errors++; $display("FAIL clean_data got %h want %h", ch_data, CLEAN); end
      checks++;
      if (nerr !== 0) begin errors++; $display("FAIL clean_sync_err got %0d want 0", nerr); end
      checks++;
   endtask

   task automatic test_prelock_garbage();
      do_reset();
      for (int i = 0; i < 13; i++) begin
         drive(1'($urandom % 2), 1'b1, 1'b0);
         if (obs() !== expv() || locked !== 1'b0) begin errors++; $display("FAIL garbage[%0d] got %h want %h", i, obs(), expv()); end
         checks++;
      end
      push_frame(CLEAN, 1'b1, '0);
      for (int i = 0; i < q.size(); i++) begin
         drive(q[i][1], 1'b1, q[i][0]);
         if (obs() !== expv()) begin errors++; $display("FAIL garbage_frame[%0d] got %h want %h", i, obs(), expv()); end
         checks++;
         if (i == 0 && locked !== 1'b1) begin errors++; $display("FAIL garbage_lock got %b want 1", locked); end
      end
      if (ch_data !== CLEAN) begin errors++; $display("FAIL garbage_data got %h want %h", ch_data, CLEAN); end
      checks++;
   endtask

   task automatic test_gapped();
      logic [CH_NUM*SLOT_W-1:0] prev;
      int i = 0, cyc = 0, npulse = 0;
      do_reset();
      push_frame(CLEAN, 1'b1, '0);
      while (i < q.size()) begin
         if (cyc % 3 == 2) begin
            prev = ch_data;
            drive(1'($urandom % 2), 1'b0, 1'($urandom % 2));
            if ({ch_valid, frm_done, sync_err} !== '0 || ch_data !== prev) begin
               errors++; $display("FAIL gap_hold[%0d] got %h/%b want %h/0", cyc, ch_data, {ch_valid, frm_done, sync_err}, prev);
            end
            checks++;
         end else begin
            drive(q[i][1], 1'b1, q[i][0]);
            i++;
            if (ch_valid != '0) npulse++;
         end
         if (obs() !== expv()) begin errors++; $display("FAIL gapped[%0d] got %h want %h", cyc, obs(), expv()); end
         checks++;
         cyc++;
      end
      if (npulse !== CH_NUM || ch_data !== CLEAN) begin
         errors++; $display("FAIL gapped_result got %0d pulses %h want %0d pulses %h", npulse, ch_data, CH_NUM, CLEAN);
      end
      checks++;
   endtask

   task automatic test_missing_sync();
      logic [CH_NUM*SLOT_W-1:0] f3 = rand_frame();
      int nerr = 0, f2_valid = 0;
      do_reset();
      push_frame(rand_frame(), 1'b1, '0);
      push_frame(rand_frame(), 1'b0, '0);
      push_frame(f3, 1'b1, '0);
      for (int i = 0; i < q.size(); i++) begin
         drive(q[i][1], 1'b1, q[i][0]);
         if (obs() !== expv()) begin errors++; $display("FAIL missing[%0d] got %h want %h", i, obs(), expv()); end
         checks++;
         if (sync_err) nerr++;
         if (i >= FRAME && i < 2 * FRAME && ch_valid != '0) f2_valid++;
         if (i == FRAME) begin
            if (locked !== 1'b0 || sync_err !== 1'b1) begin errors++; $display("FAIL missing_unlock got %b%b want 01", locked, sync_err); end
            checks++;
         end
      end
      if (nerr !== 1 || f2_valid !== 0) begin errors++; $display("FAIL missing_counts got %0d err %0d valid want 1 err 0 valid", nerr, f2_valid); end
      checks++;
      if (ch_data !== f3 || locked !== 1'b1) begin errors++; $display("FAIL missing_relock got %h/%b want %h/1", ch_data, locked, f3); end
      checks++;
   endtask

   task automatic test_early_sync();
      logic [CH_NUM*SLOT_W-1:0] fb = rand_frame();
      int cut = 2 * SL + 4, n2 = 0;
      do_reset();
      push_frame(rand_frame(), 1'b1, '0);
      while (q.size() > cut) void'(q.pop_back());
      push_frame(fb, 1'b1, '0);
      for (int i = 0; i < q.size(); i++) begin
         drive(q[i][1], 1'b1, q[i][0]);
         if (obs() !== expv()) begin errors++; $display("FAIL early[%0d] got %h want %h", i, obs(), expv()); end
         checks++;
         if (ch_valid[2]) n2++;
         if (i == cut) begin
            if (sync_err !== 1'b1 || locked !== 1'b1) begin errors++; $display("FAIL early_flag got %b%b want 11", sync_err, locked); end
            checks++;
         end
      end
      if (n2 !== 1 || ch_data !== fb) begin errors++; $display("FAIL early_result got %0d ch2 pulses %h want 1 %h", n2, ch_data, fb); end
      checks++;
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      push_frame(rand_frame(), 1'b1, '0);
      for (int i = 0; i < 20; i++) begin
         drive(q[i][1], 1'b1, q[i][0]);
         if (obs() !== expv()) begin errors++; $display("FAIL midrst_pre[%0d] got %h want %h", i, obs(), expv()); end
         checks++;
      end
      #2 sys_rst_n = 1'b0;
      #1;
      if (obs() !== '0) begin errors++; $display("FAIL midrst_async got %h want 0", obs()); end
      checks++;
      model_reset();
      q.delete();
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      push_frame(CLEAN, 1'b1, '0);
      for (int i = 0; i < q.size(); i++) begin
         drive(q[i][1], 1'b1, q[i][0]);
         if (obs() !== expv()) begin errors++; $display("FAIL midrst_post[%0d] got %h want %h", i, obs(), expv()); end
         checks++;
      end
      if (ch_data !== CLEAN) begin errors++; $display("FAIL midrst_data got %h want %h", ch_data, CLEAN); end
      checks++;
   endtask

   task automatic test_back_to_back();
      logic [CH_NUM*SLOT_W-1:0] f;
      int ndone = 0, nerr = 0;
      do_reset();
      for (int k = 0; k < 3; k++) begin f = rand_frame(); push_frame(f, 1'b1, '0); end
      for (int i = 0; i < q.size(); i++) begin
         drive(q[i][1], 1'b1, q[i][0]);
         if (obs() !== expv()) begin errors++; $display("FAIL b2b[%0d] got %h want %h", i, obs(), expv()); end
         checks++;
         if (frm_done) ndone++;
         if (sync_err) nerr++;
      end
      if (ndone !== 3 || nerr !== 0 || ch_data !== f) begin
         errors++; $display("FAIL b2b_result got %0d done %0d err %h want 3 done 0 err %h", ndone, nerr, ch_data, f);
      end
      checks++;
   endtask

   task automatic test_random();
      logic en, s;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         en = 1'($urandom % 4 != 0);
         if (m_locked && m_pos == 0) s = 1'($urandom % 12 != 0);
         else                        s = 1'($urandom % 30 == 0);
         drive(1'($urandom % 2), en, s);
         if (obs() !== expv()) begin errors++; $display("FAIL random[%0d] got %h want %h", i, obs(), expv()); end
         checks++;
      end
   endtask

`ifdef TDM_DEMUX_PARITY_EN
   task automatic test_parity();
      do_reset();
      push_frame(32'h01FF3CA5, 1'b1, 4'b0001);
      for (int i = 0; i < q.size(); i++) begin
         drive(q[i][1], 1'b1, q[i][0]);
         if (obs() !== expv()) begin errors++; $display("FAIL parity[%0d] got %h want %h", i, obs(), expv()); end
         checks++;
         if (ch_valid[0]) begin
            if (par_err !== 4'b0001 || ch_data[7:0] !== 8'hA5) begin errors++; $display("FAIL parity_flag got %b/%h want 0001/a5", par_err, ch_data[7:0]); end
            checks++;
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_clean_frame();
      test_prelock_garbage();
      test_gapped();
      test_missing_sync();
      test_early_sync();
      test_reset_mid_frame();
      test_back_to_back();
      test_random();
`ifdef TDM_DEMUX_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: the receive end of the single-wire multiplexed link. It takes a serial bit stream carrying CH_NUM channel slots per frame, locks to a frame-sync marker and shifts each slot into its own channel register. It pulses a per-channel valid strobe as each slot completes and flags sync loss. It sits downstream of the TDM mux/serializer and feeds per-channel consumers.

## Interface
Parameters:
- CH_NUM, 4, number of channel slots per frame (2..16)
- SLOT_W, 8, data bits per slot, MSB first (2..32)

Ports:
- sys_clk  input  1  system clock, all logic on rising edge
- sys_rst_n  input  1  asynchronous active-low reset
- din  input  1  serial data bit
- din_en  input  1  din valid this cycle; all counting advances only on din_en=1
- frm_sync  input  1  marks the first bit of a frame; qualified by din_en
- ch_data  output  CH_NUM*SLOT_W  channel words, channel c at [c*SLOT_W +: SLOT_W]
- ch_valid  output  CH_NUM  one-cycle pulse, bit c = channel c word just updated
- frm_done  output  1  one-cycle pulse, last slot of a frame completed
- locked  output  1  high while in RECV state
- sync_err  output  1  one-cycle pulse on sync violation

## Operation
- States: HUNT (reset state), RECV.
- Counters: bit_cnt (0..SLOT_W-1), ch_cnt (0..CH_NUM-1), shift register sh of SLOT_W bits.
- HUNT: accepted bits (din_en=1) without frm_sync are discarded. An accepted bit with frm_sync=1 is taken as bit 0 of channel 0. The block enters RECV with bit_cnt=1, ch_cnt=0.
- RECV, accepted bit: sh <= {sh[SLOT_W-2:0], din}, bit_cnt+1.
- Slot completion (accepted bit with bit_cnt=SLOT_W-1):
  - ch_data[ch_cnt] <= {sh[SLOT_W-2:0], din}; ch_valid[ch_cnt] pulses.
  - bit_cnt <= 0; ch_cnt+1, wrapping 0 after CH_NUM-1.
  - On the wrap, frm_done pulses.
- Frame boundary check (accepted bit with bit_cnt=0, ch_cnt=0, in RECV):
  - frm_sync=1: normal; bit taken as bit 0.
  - frm_sync=0: sync_err pulses, bit discarded, state -> HUNT, counters cleared.
- frm_sync=1 at any other position in RECV:
  - sync_err pulses.
  - The partial slot is dropped; no ch_valid for it.
  - The bit is taken as bit 0 of channel 0 (immediate resync, stays RECV).
- din_en=0: state, counters, sh and ch_data hold; no pulses. frm_sync is ignored when din_en=0.
- Channel words not updated this cycle hold their last value.
- Reset (any time, including mid-frame):
  - state HUNT, counters 0, sh 0.
  - ch_data all 0, ch_valid 0, frm_done 0, locked 0, sync_err 0.
  - The partial frame is lost.

## Timing
- All outputs are registered.
- Final bit of a slot sampled at edge k: the new ch_data word and ch_valid[c] are visible after edge k, and ch_valid drops after edge k+1.
- frm_done asserts in the same cycle as ch_valid[CH_NUM-1].
- sync_err asserts the cycle after the offending bit's edge, for one cycle.
- locked rises after the edge sampling the first frm_sync in HUNT. It falls after the edge that detects a missing sync.
- Throughput: one bit per cycle with din_en tied high; frames may be back-to-back with no gap.
- Minimum frame: CH_NUM*SLOT_W accepted bits.

## Configuration
- Macro TDM_DEMUX_PARITY_EN.
- Defined:
  - Each slot carries SLOT_W data bits followed by one even-parity bit; slot length is SLOT_W+1 accepted bits.
  - Adds output par_err (CH_NUM bits), pulsing bit c together with ch_valid[c] when the XOR of data and parity is 1.
  - ch_data is still updated on a parity error.
- Undefined: no parity bit, no par_err port; slot length is SLOT_W.

## Test plan
(CH_NUM=4, SLOT_W=8, macro undefined unless noted.)
- Clean frame: sync on the first bit, din_en=1, slots 0xA5, 0x3C, 0xFF, 0x01 MSB first -> ch_valid pulses 1,2,4,8 at 8-cycle spacing; ch_data=0x01FF3CA5; frm_done is concurrent with ch_valid[3]; sync_err never asserts.
- Pre-lock garbage: 13 random bits without frm_sync, then a clean frame -> garbage ignored, outputs match the clean-frame case, locked rises only after the sync bit.
- Gapped stream: the clean frame with din_en=0 on every third cycle -> identical ch_data and pulses, only stretched; nothing changes while din_en=0.
- Missing sync: two frames, the second without frm_sync on its first bit -> sync_err pulse, locked falls, no ch_valid for frame 2; a later synced frame relocks.
- Early sync: frm_sync at bit 4 of channel 2 -> sync_err pulse, channel 2 not updated, new frame decoded correctly from that bit.
- Reset mid-frame: sys_rst_n low after 20 bits -> all outputs 0 immediately; a subsequent clean frame decodes correctly. With TDM_DEMUX_PARITY_EN, slot 0x A5 with parity bit 1 -> par_err=0001 with ch_valid[0].
